// File: rtl/sdram_stream_writer_if.sv
// Bundles the upstream stream and the Avalon-MM write master into one port.
// Handshakes: a stream word moves on s_valid & s_ready; an Avalon write completes on avm_write & !avm_waitrequest.
interface sdram_stream_writer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     s_data;
  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_write;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_waitrequest;

  modport master (
    input  s_valid, s_data, avm_waitrequest,
    output s_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output s_valid, s_data, avm_waitrequest,
    input  s_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/sdram_stream_writer.sv
// Streams a fixed number of words from an upstream valid/ready source into SDRAM
// through an Avalon-MM write master, buffered by a small FIFO.
module sdram_stream_writer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 25,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic                 pll_locked,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     length,
  sdram_stream_writer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);
  localparam logic [PTR_W:0]    FILL_MAX = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                load;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    acc_cnt;
  logic [LEN_W-1:0]    wr_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      fill;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                last_pop;

  assign full  = (fill == FILL_MAX);
  assign empty = (fill == '0);

  // s_ready depends only on state and counters, never on s_valid.
  assign bus.s_ready        = (state_q == RUN) && !full && (acc_cnt < len_q);
  assign bus.avm_write      = (state_q == RUN) && !empty;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = mem[rd_ptr];
  assign bus.avm_byteenable = '1;

  assign push     = bus.s_ready && bus.s_valid;
  assign pop      = bus.avm_write && !bus.avm_waitrequest;
  assign last_pop = pop && (wr_cnt == len_q - LEN_W'(1));

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && pll_locked) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if ((len_q == '0) || last_pop) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      addr_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        len_q   <= length;
        addr_q  <= {base_addr[ADDR_W-1:1], 1'b0};
        acc_cnt <= '0;
        wr_cnt  <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        fill    <= '0;
      end else begin
        if (push) begin
          acc_cnt <= acc_cnt + LEN_W'(1);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        // Address wraps naturally at 2^ADDR_W.
        if (pop) begin
          wr_cnt <= wr_cnt + LEN_W'(1);
          rd_ptr <= rd_ptr + PTR_W'(1);
          addr_q <= addr_q + ADDR_INC;
        end
        case ({push, pop})
          2'b10:   fill <= fill + (PTR_W + 1)'(1);
          2'b01:   fill <= fill - (PTR_W + 1)'(1);
          default: fill <= fill;
        endcase
      end
    end
  end

  // Buffer storage carries no reset; validity is tracked by fill.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= bus.s_data;
  end

endmodule
